// File: rtl/uart_rx_if.sv
// Signal bundle between the UART register block and the 16x-oversampling receiver.
// Config and the serial line flow toward the receiver. The frame results flow back.
interface uart_rx_if #(
    parameter int DIV_W = 12
);
    logic             RxEn;
    logic [DIV_W-1:0] Ubrr;
    logic [1:0]       DLS;
    logic             PEN;
    logic             EPS;
    logic             STOP;
    logic             Rx;
    logic [7:0]       RxData;
    logic             RxDone;
    logic             RxStopBit;
    logic             RxParityErr;
    logic             RxBusy;

    modport master (
        output RxEn, Ubrr, DLS, PEN, EPS, STOP, Rx,
        input  RxData, RxDone, RxStopBit, RxParityErr, RxBusy
    );

    modport slave (
        input  RxEn, Ubrr, DLS, PEN, EPS, STOP, Rx,
        output RxData, RxDone, RxStopBit, RxParityErr, RxBusy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver that samples 16x per bit and frames 5-8 data bits, optional parity and 1/2 stop bits.
// Each finished frame gives a one-cycle RxDone strobe. The result registers hold until the next finished frame.
module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 12
) (
    input  logic      pClk,
    input  logic      pReset,
    uart_rx_if.slave  bus
);
    // state   | meaning
    // S_IDLE  | line idle, waiting for a low sample on a tick
    // S_START | counting to mid start bit to reject glitches
    // S_DATA  | sampling data bits LSB first at s_cnt=15
    // S_PARITY| sampling parity bit
    // S_STOP1 | sampling first stop bit
    // S_STOP2 | sampling second stop bit
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [3:0]             s_cnt_q, s_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             dls_q, dls_d;
    logic                   pen_q, pen_d;
    logic                   eps_q, eps_d;
    logic                   stop_q, stop_d;
    logic                   perr_q, perr_d;
    logic                   sb1_q, sb1_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_stop_q, rx_stop_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_busy_q, rx_busy_d;

    logic       rxs;
    logic       tick;
    logic       mid;
    logic       finish;
    logic       fin_sb;
    logic [7:0] data_mask;
    logic [2:0] last_bit;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign tick      = bus.RxEn && (div_q == bus.Ubrr);
    assign mid       = tick && (s_cnt_q == 4'd15);
    assign data_mask = 8'hFF >> (2'd3 - dls_q);
    assign last_bit  = {1'b0, dls_q} + 3'd4;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.Rx};
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dls_d     = dls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        stop_d    = stop_q;
        perr_d    = perr_q;
        sb1_d     = sb1_q;
        rx_data_d = rx_data_q;
        rx_stop_d = rx_stop_q;
        rx_perr_d = rx_perr_q;
        rx_done_d = 1'b0;
        finish    = 1'b0;
        fin_sb    = 1'b0;

        // A lowered Ubrr can strand the count above it. Wrapping on >= recovers it.
        if (!bus.RxEn || (div_q >= bus.Ubrr)) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (!bus.RxEn) begin
            state_d   = S_IDLE;
            s_cnt_d   = 4'd0;
            bit_cnt_d = 3'd0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        dls_d   = bus.DLS;
                        pen_d   = bus.PEN;
                        eps_d   = bus.EPS;
                        stop_d  = bus.STOP;
                        shift_d = 8'h00;
                        perr_d  = 1'b0;
                        s_cnt_d = 4'd0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (s_cnt_q == 4'd7) begin
                        s_cnt_d   = 4'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = rxs ? S_IDLE : S_DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        shift_d[bit_cnt_q] = rxs;
                        s_cnt_d = 4'd0;
                        if (bit_cnt_q == last_bit) begin
                            state_d = pen_q ? S_PARITY : S_STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (mid) begin
                        // Zero means the frame carried correct even or odd parity.
                        perr_d  = (^(shift_q & data_mask)) ^ rxs ^ ~eps_q;
                        s_cnt_d = 4'd0;
                        state_d = S_STOP1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                S_STOP1: begin
                    if (mid) begin
                        sb1_d   = rxs;
                        s_cnt_d = 4'd0;
                        if (stop_q && rxs) begin
                            state_d = S_STOP2;
                        end else begin
                            finish = 1'b1;
                            fin_sb = rxs;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                S_STOP2: begin
                    if (mid) begin
                        finish = 1'b1;
                        fin_sb = sb1_q & rxs;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    s_cnt_d = 4'd0;
                end
            endcase
        end

        if (finish) begin
            rx_data_d = shift_q & data_mask;
            rx_perr_d = pen_q & perr_q;
            rx_stop_d = fin_sb;
            rx_done_d = 1'b1;
            state_d   = S_IDLE;
            s_cnt_d   = 4'd0;
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            sync_q    <= '1;
            state_q   <= S_IDLE;
            div_q     <= '0;
            s_cnt_q   <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            dls_q     <= 2'd0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            stop_q    <= 1'b0;
            perr_q    <= 1'b0;
            sb1_q     <= 1'b0;
            rx_data_q <= 8'h00;
            rx_done_q <= 1'b0;
            rx_stop_q <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_busy_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            div_q     <= div_d;
            s_cnt_q   <= s_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dls_q     <= dls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            stop_q    <= stop_d;
            perr_q    <= perr_d;
            sb1_q     <= sb1_d;
            rx_data_q <= rx_data_d;
            rx_done_q <= rx_done_d;
            rx_stop_q <= rx_stop_d;
            rx_perr_q <= rx_perr_d;
            rx_busy_q <= rx_busy_d;
        end
    end

    assign bus.RxData      = rx_data_q;
    assign bus.RxDone      = rx_done_q;
    assign bus.RxStopBit   = rx_stop_q;
    assign bus.RxParityErr = rx_perr_q;
    assign bus.RxBusy      = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of framed bytes followed by hand-written sequences.
// The hand-written sequences cover reset, glitch, abort, back-to-back and break behaviour.
module tb_uart_rx;
    logic pClk;
    logic pReset;

    uart_rx_if #(.DIV_W(12)) bus();

    uart_rx #(.SYNC_STAGES(2), .DIV_W(12)) dut (
        .pClk   (pClk),
        .pReset (pReset),
        .bus    (bus)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dls;
        logic        pen;
        logic        eps;
        logic        stop;
        logic        par;
        logic        sb1;
        logic        sb2;
        logic [11:0] ubrr;
        logic [7:0]  exp_data;
        logic        exp_sb;
        logic        exp_pe;
    } vec_t;

    localparam int NV = 9;
    vec_t vec[NV];

    int checks = 0;
    int errors = 0;

    int         done_cnt = 0;
    logic [7:0] cap_data[$];
    logic [7:0] last_data = 8'h00;
    logic       last_sb = 1'b0;
    logic       last_pe = 1'b0;

    always @(negedge pClk) begin
        if (bus.RxDone === 1'b1) begin
            done_cnt++;
            cap_data.push_back(bus.RxData);
            last_data = bus.RxData;
            last_sb   = bus.RxStopBit;
            last_pe   = bus.RxParityErr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge pClk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int clks);
        bus.Rx = b;
        wait_clks(clks);
    endtask

    task automatic set_cfg(input vec_t v);
        bus.DLS  = v.dls;
        bus.PEN  = v.pen;
        bus.EPS  = v.eps;
        bus.STOP = v.stop;
        bus.Ubrr = v.ubrr;
    endtask

    task automatic send_frame(input vec_t v);
        int bp;
        bp = 16 * (int'(v.ubrr) + 1);
        send_bit(1'b0, bp);
        for (int i = 0; i < int'(v.dls) + 5; i++) send_bit(v.data[i], bp);
        if (v.pen) send_bit(v.par, bp);
        send_bit(v.sb1, bp);
        if (v.stop) send_bit(v.sb2, bp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n0;
        int   bp;
        logic [7:0] b0, b1;

        //          data   dls   pen   eps   stop  par   sb1   sb2   ubrr    exp    sb    pe
        vec[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 8'hA5, 1'b1, 1'b0};
        vec[1] = '{8'h5A, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'd3, 8'h5A, 1'b1, 1'b0};
        vec[2] = '{8'h5A, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd3, 8'h5A, 1'b1, 1'b1};
        vec[3] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 8'h1F, 1'b1, 1'b0};
        vec[4] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 8'h3C, 1'b0, 1'b0};
        vec[5] = '{8'hE3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd1, 8'h03, 1'b1, 1'b0};
        vec[6] = '{8'h2B, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd1, 8'h2B, 1'b1, 1'b0};
        vec[7] = '{8'h5A, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 8'h5A, 1'b0, 1'b0};
        vec[8] = '{8'h96, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd2, 8'h96, 1'b1, 1'b0};

        pReset   = 1'b0;
        bus.Rx   = 1'b1;
        bus.RxEn = 1'b1;
        set_cfg(vec[0]);
        #23;
        pReset = 1'b1;
        wait_clks(500);
        chk("reset_data", bus.RxData, 8'h00);
        chk("reset_stop", bus.RxStopBit, 1'b0);
        chk("reset_perr", bus.RxParityErr, 1'b0);
        chk("reset_busy", bus.RxBusy, 1'b0);
        chk("reset_nodone", done_cnt, 0);

        for (int i = 0; i < NV; i++) begin
            v = vec[i];
            set_cfg(v);
            wait_clks(40);
            n0 = done_cnt;
            send_frame(v);
            bp = 16 * (int'(v.ubrr) + 1);
            send_bit(1'b1, 2 * bp);
            chk($sformatf("v%0d_done", i), done_cnt - n0, 1);
            chk($sformatf("v%0d_data", i), last_data, v.exp_data);
            chk($sformatf("v%0d_stop", i), last_sb, v.exp_sb);
            chk($sformatf("v%0d_perr", i), last_pe, v.exp_pe);
            chk($sformatf("v%0d_busy", i), bus.RxBusy, 1'b0);
        end

        // A 4-clock glitch is gone by the mid start bit sample.
        v = vec[0];
        set_cfg(v);
        wait_clks(40);
        n0 = done_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 60);
        chk("glitch_nodone", done_cnt - n0, 0);
        chk("glitch_busy", bus.RxBusy, 1'b0);

        // Disable the receiver partway through data bit 3 of 0x77.
        n0 = done_cnt;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 8);
        chk("abort_busy_mid", bus.RxBusy, 1'b1);
        bus.RxEn = 1'b0;
        send_bit(1'b1, 100);
        chk("abort_nodone", done_cnt - n0, 0);
        chk("abort_data_held", bus.RxData, vec[NV-1].exp_data);
        chk("abort_busy", bus.RxBusy, 1'b0);
        bus.RxEn = 1'b1;
        wait_clks(40);

        n0 = done_cnt;
        v.data = 8'h01;
        send_frame(v);
        v.data = 8'hFF;
        send_frame(v);
        send_bit(1'b1, 48);
        chk("b2b_count", done_cnt - n0, 2);
        b0 = 8'hxx;
        b1 = 8'hxx;
        if (cap_data.size() >= 2) begin
            b0 = cap_data[cap_data.size()-2];
            b1 = cap_data[cap_data.size()-1];
        end
        chk("b2b_first", b0, 8'h01);
        chk("b2b_second", b1, 8'hFF);

        // Held-low line: two complete frames fit in 400 clocks at Ubrr=0.
        n0 = done_cnt;
        send_bit(1'b0, 400);
        chk("break_count", done_cnt - n0, 2);
        chk("break_stop", last_sb, 1'b0);
        chk("break_data", last_data, 8'h00);
        send_bit(1'b1, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
